serial_subtractor_8bits: RTL and testbench



---
 rtl/serial_subtractor_8bits.sv | 131 +++++++++++++
 tb/tb_serial_subtractor_8bits.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_8bits.sv
// Bit-serial subtractor: Sub_in1 - Sub_in2 - Sub_bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop, with start/done handshake.
module serial_subtractor_8bits #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Sub_start,
    input  logic [WIDTH-1:0] Sub_in1,
    input  logic [WIDTH-1:0] Sub_in2,
    input  logic             Sub_bin,
    output logic             Sub_busy,
    output logic             Sub_done,
    output logic [WIDTH-1:0] Sub_diff,
    output logic             Sub_bout,
    output logic             Sub_ovf,
    output logic             Sub_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              br_q, br_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;

    logic              cell_diff;
    logic              cell_bout;
    logic              accept;

    // Single full-subtractor cell operating on the current LSBs.
    assign cell_diff = a_q[0] ^ b_q[0] ^ br_q;
    assign cell_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = Sub_start;
            end
            StShift: begin
                a_d  = {1'b0, a_q[WIDTH-1:1]};
                b_d  = {1'b0, b_q[WIDTH-1:1]};
                br_d = cell_bout;
                r_d  = {cell_diff, r_q[WIDTH-1:1]};
                if (cnt_q == CntLast) begin
                    // MSB edge: br_q is the borrow into the MSB, cell_bout the borrow out.
                    diff_d  = {cell_diff, r_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    ovf_d   = br_q ^ cell_bout;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (Sub_start) begin
                    accept = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            a_d     = Sub_in1;
            b_d     = Sub_in2;
            br_d    = Sub_bin;
            r_d     = '0;
            cnt_d   = '0;
            state_d = StShift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            r_q     <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Sub_busy = (state_q == StShift);
    assign Sub_done = (state_q == StDone);
    assign Sub_diff = diff_q;
    assign Sub_bout = bout_q;
    assign Sub_ovf  = ovf_q;
    assign Sub_zero = (diff_q == '0);

endmodule

// File: tb/tb_serial_subtractor_8bits.sv
// Directed bench for serial_subtractor_8bits: vector table plus hand-written
// sequences for ignored start, back-to-back operation and asynchronous reset.
module tb_serial_subtractor_8bits;

    logic       clk;
    logic       rst_n;
    logic       Sub_start;
    logic [7:0] Sub_in1;
    logic [7:0] Sub_in2;
    logic       Sub_bin;
    logic       Sub_busy;
    logic       Sub_done;
    logic [7:0] Sub_diff;
    logic       Sub_bout;
    logic       Sub_ovf;
    logic       Sub_zero;

    int total;
    int bad;

    serial_subtractor_8bits #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Sub_start(Sub_start),
        .Sub_in1  (Sub_in1),
        .Sub_in2  (Sub_in2),
        .Sub_bin  (Sub_bin),
        .Sub_busy (Sub_busy),
        .Sub_done (Sub_done),
        .Sub_diff (Sub_diff),
        .Sub_bout (Sub_bout),
        .Sub_ovf  (Sub_ovf),
        .Sub_zero (Sub_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for its done pulse.
    // lat counts edges after the accepting edge; busy_cnt counts busy cycles.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        Sub_in1   = a;
        Sub_in2   = b;
        Sub_bin   = bin;
        Sub_start = 1'b1;
        @(posedge clk);
        #1;
        Sub_start = 1'b0;
        Sub_in1   = ~a;
        Sub_in2   = ~b;
        Sub_bin   = ~bin;
        busy_cnt  = Sub_busy ? 1 : 0;
        lat       = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (Sub_done) break;
            if (Sub_busy) busy_cnt++;
        end
    endtask

    int lat;
    int busy_cnt;
    int done_cnt;
    int done_at;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        Sub_start = 1'b0;
        Sub_in1   = 8'h00;
        Sub_in2   = 8'h00;
        Sub_bin   = 1'b0;

        vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        #3;
        chk("rst_busy", Sub_busy, 0);
        chk("rst_done", Sub_done, 0);
        chk("rst_diff", Sub_diff, 0);
        chk("rst_bout", Sub_bout, 0);
        chk("rst_ovf", Sub_ovf, 0);
        chk("rst_zero", Sub_zero, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, busy_cnt);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_busy_cycles", i), busy_cnt, 8);
            chk($sformatf("v%0d_diff", i), Sub_diff, vecs[i].diff);
            chk($sformatf("v%0d_bout", i), Sub_bout, vecs[i].bout);
            chk($sformatf("v%0d_ovf", i), Sub_ovf, vecs[i].ovf);
            chk($sformatf("v%0d_zero", i), Sub_zero, vecs[i].zero);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_one_cycle", i), Sub_done, 0);
            chk($sformatf("v%0d_diff_hold", i), Sub_diff, vecs[i].diff);
        end

        // Start during SHIFT must be ignored.
        @(negedge clk);
        Sub_in1   = 8'h10;
        Sub_in2   = 8'h01;
        Sub_bin   = 1'b0;
        Sub_start = 1'b1;
        @(posedge clk);
        #1;
        Sub_start = 1'b0;
        done_cnt  = 0;
        done_at   = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                Sub_in1   = 8'hAA;
                Sub_in2   = 8'h55;
                Sub_start = 1'b1;
            end else if (i == 4) begin
                Sub_start = 1'b0;
            end
            if (Sub_done) begin
                done_cnt++;
                done_at = i;
            end
        end
        chk("ign_done_count", done_cnt, 1);
        chk("ign_done_edge", done_at, 8);
        chk("ign_diff", Sub_diff, 8'h0F);
        chk("ign_busy_after", Sub_busy, 0);

        // Back-to-back: start held through the DONE cycle.
        do_op(8'h20, 8'h05, 1'b0, lat, busy_cnt);
        chk("b2b_op1_latency", lat, 8);
        chk("b2b_op1_diff", Sub_diff, 8'h1B);
        Sub_in1   = 8'h09;
        Sub_in2   = 8'h03;
        Sub_bin   = 1'b0;
        Sub_start = 1'b1;
        @(posedge clk);
        #1;
        Sub_start = 1'b0;
        Sub_in1   = 8'hEE;
        chk("b2b_no_gap_busy", Sub_busy, 1);
        lat = 1;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) chk("b2b_diff_stable", Sub_diff, 8'h1B);
            if (Sub_done) break;
        end
        chk("b2b_op2_gap", lat, 9);
        chk("b2b_op2_diff", Sub_diff, 8'h06);

        // Asynchronous reset mid-SHIFT.
        @(negedge clk);
        Sub_in1   = 8'h33;
        Sub_in2   = 8'h11;
        Sub_bin   = 1'b0;
        Sub_start = 1'b1;
        @(posedge clk);
        #1;
        Sub_start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", Sub_busy, 0);
        chk("arst_done", Sub_done, 0);
        chk("arst_diff", Sub_diff, 0);
        chk("arst_bout", Sub_bout, 0);
        chk("arst_ovf", Sub_ovf, 0);
        chk("arst_zero", Sub_zero, 1);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (Sub_done) done_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (Sub_done) done_cnt++;
        end
        chk("arst_no_done", done_cnt, 0);
        do_op(8'h03, 8'h01, 1'b0, lat, busy_cnt);
        chk("arst_after_latency", lat, 8);
        chk("arst_after_diff", Sub_diff, 8'h02);
        chk("arst_after_bout", Sub_bout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
